// File: rtl/mips_fetch_pkg.sv
// Shared definitions for the instruction-fetch / next-PC unit.
// Holds the next-PC select codes, the FSM state encoding, the nop word
// and the default reset/exception vectors.
package mips_fetch_pkg;

    // Next-PC select codes (iOrigPC)
    localparam logic [2:0] ORIGPC_SEQ  = 3'b000;  // PC+4
    localparam logic [2:0] ORIGPC_BEQ  = 3'b001;  // Zero ? BR : PC+4
    localparam logic [2:0] ORIGPC_J    = 3'b010;  // jump index
    localparam logic [2:0] ORIGPC_REG  = 3'b011;  // jr / jalr
    localparam logic [2:0] ORIGPC_ERET = 3'b100;  // COP0 EPC
    localparam logic [2:0] ORIGPC_BNE  = 3'b101;  // !Zero ? BR : PC+4
    localparam logic [2:0] ORIGPC_BC1T = 3'b110;  // Flag ? BR : PC+4
    localparam logic [2:0] ORIGPC_BC1F = 3'b111;  // !Flag ? BR : PC+4

    // Fetch FSM states
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_VALID = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_WORD         = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_KTEXT_PC = 32'h8000_0180;
    localparam logic [31:0] DEFAULT_BOOT_LO  = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_BOOT_HI  = 32'h0000_01FC;

endpackage

// File: rtl/fetch_pc_unit_next_pc_sel.sv
// next_pc_sel: combinational next-PC target mux with alignment check.
// Ports:
//   pc4          current PC + 4
//   orig_pc      next-PC select code (ORIGPC_*)
//   zero, flag   ALU zero / FPU condition flag
//   branch_imm   sign-extended word offset
//   jump_idx     26-bit jump index
//   reg_target   register target (jr/jalr)
//   eret_target  EPC target (eret)
//   exc          exception taken, forces the exception vector
//   next_pc_c    selected target with bits [1:0] cleared
//   addr_err_c   selected target was not word aligned
module next_pc_sel
    import mips_fetch_pkg::*;
#(
    parameter int unsigned ADDR_W   = 32,
    parameter logic [31:0] KTEXT_PC = DEFAULT_KTEXT_PC
) (
    input  logic [ADDR_W-1:0] pc4,
    input  logic [2:0]        orig_pc,
    input  logic              zero,
    input  logic              flag,
    input  logic [ADDR_W-1:0] branch_imm,
    input  logic [25:0]       jump_idx,
    input  logic [ADDR_W-1:0] reg_target,
    input  logic [ADDR_W-1:0] eret_target,
    input  logic              exc,
    output logic [ADDR_W-1:0] next_pc_c,
    output logic              addr_err_c
);

    localparam logic [ADDR_W-1:0] KTEXT_A = ADDR_W'(KTEXT_PC);

    logic [ADDR_W-1:0] br_off;
    logic [ADDR_W-1:0] br_target;
    logic [ADDR_W-1:0] j_target;
    logic [ADDR_W-1:0] raw;

    // Branch offset is in words; the add wraps modulo 2^ADDR_W
    assign br_off    = branch_imm << 2;
    assign br_target = pc4 + br_off;
    assign j_target  = {pc4[ADDR_W-1:28], jump_idx, 2'b00};

    // Target select; exception overrides every source
    always_comb begin
        raw = pc4;
        case (orig_pc)
            ORIGPC_SEQ:  raw = pc4;
            ORIGPC_BEQ:  raw = zero  ? br_target : pc4;
            ORIGPC_J:    raw = j_target;
            ORIGPC_REG:  raw = reg_target;
            ORIGPC_ERET: raw = eret_target;
            ORIGPC_BNE:  raw = !zero ? br_target : pc4;
            ORIGPC_BC1T: raw = flag  ? br_target : pc4;
            ORIGPC_BC1F: raw = !flag ? br_target : pc4;
            default:     raw = pc4;
        endcase
        if (exc) begin
            raw = KTEXT_A;
        end
    end

    // Only register/EPC sources can be misaligned; force word alignment
    assign next_pc_c  = {raw[ADDR_W-1:2], 2'b00};
    assign addr_err_c = |raw[1:0];

endmodule

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: instruction-fetch / next-PC unit with req/ack memory handshake.
// Optional feature: FETCH_TIMEOUT_EN adds an 8-bit fetch timeout counter that
// substitutes a nop and raises a sticky oBusErr when iIAck never arrives.
// Ports:
//   iCLK, iRST     clock, asynchronous active-high reset
//   iInitialPC     PC loaded while iRST is high
//   iAdvance       back-end accepts oInstr
//   iOrigPC        next-PC select; iZero/iFlag branch conditions
//   iBranchImm, iJumpIdx, iRegTarget, iEretTarget   target operands
//   iExcOccurred   exception taken, overrides iOrigPC
//   oIReq, oIAddr  memory request / address; iIAck, iIData memory response
//   oPC, oPC4      current PC and PC+4
//   oInstr, oInstrValid   held instruction and its valid flag
//   oEPCBase       last PC committed by a non-exception advance
//   oBootWindow    oPC inside [BOOT_LO, BOOT_HI]
//   oAddrErr       one-cycle pulse on a misaligned next PC
//   oBusErr        sticky fetch timeout (0 without FETCH_TIMEOUT_EN)
module fetch_pc_unit
    import mips_fetch_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned INSTR_W     = 32,
    parameter logic [31:0] KTEXT_PC    = DEFAULT_KTEXT_PC,
    parameter logic [31:0] BOOT_LO     = DEFAULT_BOOT_LO,
    parameter logic [31:0] BOOT_HI     = DEFAULT_BOOT_HI,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic               iCLK,
    input  logic               iRST,
    input  logic [ADDR_W-1:0]  iInitialPC,
    input  logic               iAdvance,
    input  logic [2:0]         iOrigPC,
    input  logic               iZero,
    input  logic               iFlag,
    input  logic [ADDR_W-1:0]  iBranchImm,
    input  logic [25:0]        iJumpIdx,
    input  logic [ADDR_W-1:0]  iRegTarget,
    input  logic [ADDR_W-1:0]  iEretTarget,
    input  logic               iExcOccurred,
    output logic               oIReq,
    output logic [ADDR_W-1:0]  oIAddr,
    input  logic               iIAck,
    input  logic [INSTR_W-1:0] iIData,
    output logic [ADDR_W-1:0]  oPC,
    output logic [ADDR_W-1:0]  oPC4,
    output logic [INSTR_W-1:0] oInstr,
    output logic               oInstrValid,
    output logic [ADDR_W-1:0]  oEPCBase,
    output logic               oBootWindow,
    output logic               oAddrErr,
    output logic               oBusErr
);

    localparam logic [ADDR_W-1:0] BOOT_LO_A = ADDR_W'(BOOT_LO);
    localparam logic [ADDR_W-1:0] BOOT_HI_A = ADDR_W'(BOOT_HI);
    localparam logic [ADDR_W-1:0] PC_STEP   = ADDR_W'(4);

    // Window test done as an offset compare so BOOT_LO = 0 needs no special case
    function automatic logic in_boot(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] off;
        off = a - BOOT_LO_A;
        return off <= (BOOT_HI_A - BOOT_LO_A);
    endfunction

    fetch_state_e      state_q, state_d;
    logic              load_instr;
    logic              accept;
    logic [ADDR_W-1:0] next_pc_c;
    logic              addr_err_c;

    logic [ADDR_W-1:0]  pc_q, pc4_q, epc_q;
    logic [INSTR_W-1:0] instr_q;
    logic               ireq_q, valid_q, boot_q, addr_err_q;

    next_pc_sel #(
        .ADDR_W   (ADDR_W),
        .KTEXT_PC (KTEXT_PC)
    ) u_next_pc_sel (
        .pc4         (pc4_q),
        .orig_pc     (iOrigPC),
        .zero        (iZero),
        .flag        (iFlag),
        .branch_imm  (iBranchImm),
        .jump_idx    (iJumpIdx),
        .reg_target  (iRegTarget),
        .eret_target (iEretTarget),
        .exc         (iExcOccurred),
        .next_pc_c   (next_pc_c),
        .addr_err_c  (addr_err_c)
    );

`ifdef FETCH_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

    logic [7:0] to_cnt_q;
    logic       timeout_c;
    logic       load_nop;
    logic       bus_err_q;

    // Fires on the last allowed request cycle that still sees no ack
    assign timeout_c = (state_q == S_REQ) && !iIAck && (to_cnt_q == TO_LAST);
`endif

    // FSM state register
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state and datapath strobes
    always_comb begin
        state_d    = state_q;
        load_instr = 1'b0;
        accept     = 1'b0;
`ifdef FETCH_TIMEOUT_EN
        load_nop   = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
            end
            S_REQ: begin
                if (iIAck) begin
                    load_instr = 1'b1;
                    state_d    = S_VALID;
                end
`ifdef FETCH_TIMEOUT_EN
                else if (timeout_c) begin
                    load_nop = 1'b1;
                    state_d  = S_VALID;
                end
`endif
            end
            S_VALID: begin
                if (iAdvance) begin
                    accept  = 1'b1;
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // PC, EPC base, instruction hold and status registers
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            pc_q       <= iInitialPC;
            pc4_q      <= iInitialPC + PC_STEP;
            epc_q      <= iInitialPC;
            boot_q     <= in_boot(iInitialPC);
            instr_q    <= '0;
            ireq_q     <= 1'b0;
            valid_q    <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            ireq_q     <= (state_d == S_REQ);
            valid_q    <= (state_d == S_VALID);
            addr_err_q <= accept && addr_err_c;
            if (load_instr) begin
                instr_q <= iIData;
            end
`ifdef FETCH_TIMEOUT_EN
            if (load_nop) begin
                instr_q <= INSTR_W'(NOP_WORD);
            end
`endif
            if (accept) begin
                pc_q   <= next_pc_c;
                pc4_q  <= next_pc_c + PC_STEP;
                boot_q <= in_boot(next_pc_c);
                if (!iExcOccurred) begin
                    epc_q <= next_pc_c;
                end
            end
        end
    end

`ifdef FETCH_TIMEOUT_EN
    // Timeout counter: restarts on each entry to S_REQ, sticky error flag
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            to_cnt_q  <= '0;
            bus_err_q <= 1'b0;
        end else begin
            if ((state_d == S_REQ) && (state_q != S_REQ)) begin
                to_cnt_q <= '0;
            end else if ((state_q == S_REQ) && !iIAck) begin
                to_cnt_q <= to_cnt_q + 8'd1;
            end
            if (timeout_c) begin
                bus_err_q <= 1'b1;
            end
        end
    end

    assign oBusErr = bus_err_q;
`else
    assign oBusErr = 1'b0;
`endif

    assign oIReq       = ireq_q;
    assign oIAddr      = pc_q;
    assign oPC         = pc_q;
    assign oPC4        = pc4_q;
    assign oInstr      = instr_q;
    assign oInstrValid = valid_q;
    assign oEPCBase    = epc_q;
    assign oBootWindow = boot_q;
    assign oAddrErr    = addr_err_q;

endmodule
